booth_mul_seq: RTL and testbench



---
 rtl/mul_pkg.sv | 37 +++
 rtl/booth_recoder.sv | 41 ++++
 rtl/booth_mul_seq.sv | 123 ++++++++++++
 tb/tb_booth_mul_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the radix-4 Booth multiplier datapath:
//   - state_e       : sequencer states (IDLE, RUN, DONE)
//   - booth_digit_e : recoded radix-4 digit {0, +1, +2, -1, -2}
//   - booth_digit() : maps a 3-bit multiplier window to its digit
// ----------------------------------------------------------------------------
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS1 = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG1 = 3'd3,
    DIG_NEG2 = 3'd4
  } booth_digit_e;

  // Window is {b[2i+1], b[2i], b[2i-1]}; digit = -2*w[2] + w[1] + w[0].
  function automatic booth_digit_e booth_digit(input logic [2:0] window);
    booth_digit_e dig;
    case (window)
      3'b001, 3'b010: dig = DIG_POS1;
      3'b011:         dig = DIG_POS2;
      3'b100:         dig = DIG_NEG2;
      3'b101, 3'b110: dig = DIG_NEG1;
      default:        dig = DIG_ZERO;  // 000 and 111
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// ----------------------------------------------------------------------------
// booth_recoder
// Combinational radix-4 Booth recoder. Turns a 3-bit multiplier window into
// the three controls a partial-product selector needs.
//   window_i : {b[2i+1], b[2i], b[2i-1]}
//   sel2x_o  : use 2*M instead of M
//   negate_o : subtract the selected multiple instead of adding it
//   zero_o   : digit is zero, partial product is 0
// ----------------------------------------------------------------------------
module booth_recoder
  import mul_pkg::*;
(
  input  logic [2:0] window_i,
  output logic       sel2x_o,
  output logic       negate_o,
  output logic       zero_o
);

  booth_digit_e digit;

  assign digit = booth_digit(window_i);

  // NOTE: every output gets a default before the case; a path that leaves a
  // combinational output unassigned infers a latch.
  always_comb begin
    sel2x_o  = 1'b0;
    negate_o = 1'b0;
    zero_o   = 1'b0;
    case (digit)
      DIG_POS1: ;
      DIG_POS2: sel2x_o = 1'b1;
      DIG_NEG1: negate_o = 1'b1;
      DIG_NEG2: begin
        sel2x_o  = 1'b1;
        negate_o = 1'b1;
      end
      default:  zero_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/booth_mul_seq.sv
// ----------------------------------------------------------------------------
// booth_mul_seq
// Sequential signed WIDTH x WIDTH multiplier, radix-4 Booth, one recoded
// digit per clock (WIDTH/2 RUN cycles). Result lands in the HI/LO pair.
//   Clock   : system clock, rising edge
//   Reset_n : asynchronous active-low reset
//   Start   : request a multiply (sampled only in IDLE)
//   A, B    : signed multiplicand / multiplier, latched on acceptance
//   Busy    : high during RUN
//   Done    : one-cycle pulse, Zhi/Zlo valid from this cycle
//   Zhi/Zlo : upper / lower half of the 2*WIDTH-bit signed product
// ----------------------------------------------------------------------------
module booth_mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH/2) + 1
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Zhi,
  output logic [WIDTH-1:0] Zlo
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH/2 - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [WIDTH+1:0]   m_q,     m_d;     // multiplicand, sign-extended by 2
  logic [WIDTH+1:0]   acc_q,   acc_d;   // high accumulator
  logic [WIDTH:0]     mq_q,    mq_d;    // multiplier / product-low, extra 0 LSB
  logic [WIDTH-1:0]   zhi_q,   zhi_d;
  logic [WIDTH-1:0]   zlo_q,   zlo_d;

  logic               sel2x, negate, zero;
  logic [WIDTH+1:0]   m_mult, pp, sum, acc_sh;
  logic [WIDTH:0]     mq_sh;

  booth_recoder u_recoder (
    .window_i (mq_q[2:0]),
    .sel2x_o  (sel2x),
    .negate_o (negate),
    .zero_o   (zero)
  );

  // WIDTH+2 bits hold +2^WIDTH, the largest magnitude (-2 * -2^(WIDTH-1)).
  assign m_mult = sel2x ? {m_q[WIDTH:0], 1'b0} : m_q;
  assign pp     = zero ? '0 : (negate ? -m_mult : m_mult);
  assign sum    = acc_q + pp;

  // Arithmetic right shift of the {acc, mq} pair by one radix-4 digit.
  assign acc_sh = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
  assign mq_sh  = {sum[1:0], mq_q[WIDTH:2]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          m_d     = {{2{A[WIDTH-1]}}, A};
          mq_d    = {B, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_sh;
        mq_d  = mq_sh;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Product bits [2*WIDTH:1] of the shifted pair.
          zhi_d   = acc_sh[WIDTH-1:0];
          zlo_d   = mq_sh[WIDTH:1];
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  // NOTE: datapath registers are reset too, so an abandoned operation leaves
  // no stale operands or partial product behind.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      m_q     <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      zhi_q   <= '0;
      zlo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign Done = (state_q == ST_DONE);
  assign Zhi  = zhi_q;
  assign Zlo  = zlo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_booth_mul_seq
// Self-checking bench for booth_mul_seq (WIDTH=32). Expected products come
// from plain 64-bit signed multiplication of the operands the bench applied.
// ----------------------------------------------------------------------------
module tb_booth_mul_seq;

  logic        Clock;
  logic        Reset_n;
  logic        Start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Zhi;
  logic [31:0] Zlo;

  int errors = 0;
  int checks = 0;

  booth_mul_seq dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Zhi     (Zhi),
    .Zlo     (Zlo)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int    ia;
    int    ib;
    longint p;
    ia = a;
    ib = b;
    p  = longint'(ia) * longint'(ib);
    return p;
  endfunction

  // Accept an operation: Start high through one rising edge (DUT in IDLE).
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge Clock);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clock);
    #1 Start = 1'b0;
  endtask

  // Edges are counted with the acceptance edge as edge 1.
  task automatic wait_done(input bit scramble, output logic [63:0] prod,
                           output int edges, output bit ok);
    ok    = 1'b0;
    edges = 1;
    prod  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge Clock);
      if (Done) begin
        prod = {Zhi, Zlo};
        ok   = 1'b1;
      end else begin
        if (scramble) begin
          A = $urandom;
          B = $urandom;
        end
        @(posedge Clock);
        edges++;
      end
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp,
                               input bit scramble);
    logic [63:0] prod;
    int          edges;
    bit          ok;
    start_op(a, b);
    wait_done(scramble, prod, edges, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: Done not seen within 40 edges", name);
    end else begin
      if (prod !== exp) begin
        errors++;
        $display("FAIL %s_product: got %h, expected %h", name, prod, exp);
      end
      checks++;
      if (edges !== 17) begin
        errors++;
        $display("FAIL %s_latency: Done after edge %0d, expected edge 17", name, edges);
      end
      @(negedge Clock);
      checks++;
      if (Done !== 1'b0) begin
        errors++;
        $display("FAIL %s_done_width: Done still %b one cycle later, expected 0", name, Done);
      end
    end
  endtask

  task automatic test_power_on;
    repeat (2) @(negedge Clock);
    checks++;
    if ({Busy, Done, Zhi, Zlo} !== '0) begin
      errors++;
      $display("FAIL power_on: Busy=%b Done=%b Zhi=%h Zlo=%h, expected all 0", Busy, Done, Zhi, Zlo);
    end
    Reset_n = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_basic_signs;
    run_and_check("pos_pos", 32'd6, 32'd3, 64'h00000000_00000012, 1'b0);
    run_and_check("pos_neg", 32'd6, -32'sd3, 64'hFFFFFFFF_FFFFFFEE, 1'b0);
    run_and_check("zero", 32'd0, 32'hDEADBEEF, 64'h0, 1'b0);
  endtask

  // Reset after 5 RUN cycles of 6*3; outputs clear before any clock edge.
  task automatic test_reset;
    bit seen_activity;
    start_op(32'd6, 32'd3);
    repeat (5) @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: Busy=%b Done=%b, expected 0 0", Busy, Done);
    end
    checks++;
    if ({Zhi, Zlo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_result: got %h, expected 0", {Zhi, Zlo});
    end
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    seen_activity = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clock);
      if (Done || Busy) seen_activity = 1'b1;
    end
    checks++;
    if (seen_activity) begin
      errors++;
      $display("FAIL reset_abandon: Busy/Done activity after reset release, expected none");
    end
  endtask

  task automatic test_extremes;
    run_and_check("min_min", 32'h80000000, 32'h80000000, 64'h40000000_00000000, 1'b0);
    run_and_check("max_max", 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF_00000001, 1'b0);
    run_and_check("min_one", 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000, 1'b0);
    run_and_check("neg_min", 32'hFFFFFFFF, 32'h80000000, 64'h00000000_80000000, 1'b0);
  endtask

  task automatic test_start_while_busy;
    int          done_cnt;
    int          first;
    logic [63:0] prod;
    done_cnt = 0;
    first    = -1;
    prod     = '0;
    start_op(32'd6, 32'd3);
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clock);
      if (i == 3) begin
        A = 32'd9;
        B = 32'd9;
        Start = 1'b1;
      end else if (i == 4) begin
        Start = 1'b0;
      end
      if (Done) begin
        done_cnt++;
        if (first < 0) begin
          first = i;
          prod  = {Zhi, Zlo};
        end
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL busy_done_count: %0d Done cycles, expected 1", done_cnt);
    end
    checks++;
    if (first !== 17) begin
      errors++;
      $display("FAIL busy_latency: Done after edge %0d, expected 17", first);
    end
    checks++;
    if (prod !== 64'h12) begin
      errors++;
      $display("FAIL busy_product: got %h, expected %h", prod, 64'h12);
    end
  endtask

  task automatic test_operand_stability;
    run_and_check("stable_a", 32'd5, -32'sd7, 64'hFFFFFFFF_FFFFFFDD, 1'b1);
    run_and_check("stable_b", 32'h12345678, 32'h9ABCDEF0,
                  ref_mul(32'h12345678, 32'h9ABCDEF0), 1'b1);
  endtask

  function automatic logic [31:0] pick_operand;
    case ($urandom_range(0, 9))
      0:       return 32'h80000000;
      1:       return 32'h7FFFFFFF;
      2:       return 32'h0;
      3:       return 32'hFFFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  // Start held high: one op per IDLE visit, Done period = 16 RUN + DONE + IDLE.
  task automatic test_random_back_to_back(input int n);
    logic [63:0] exp;
    int          got;
    int          last;
    got  = 0;
    last = -1;
    @(negedge Clock);
    A = pick_operand();
    B = pick_operand();
    exp = ref_mul(A, B);
    Start = 1'b1;
    for (int cyc = 0; cyc < n * 18 + 60 && got < n; cyc++) begin
      @(negedge Clock);
      if (Done) begin
        checks++;
        if ({Zhi, Zlo} !== exp) begin
          errors++;
          $display("FAIL rand_product[%0d]: got %h, expected %h", got, {Zhi, Zlo}, exp);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last !== 18) begin
            errors++;
            $display("FAIL rand_gap[%0d]: %0d cycles between Dones, expected 18", got, cyc - last);
          end
        end
        last = cyc;
        got++;
        if (got < n) begin
          A = pick_operand();
          B = pick_operand();
          exp = ref_mul(A, B);
        end else begin
          Start = 1'b0;
        end
      end
    end
    Start = 1'b0;
    checks++;
    if (got !== n) begin
      errors++;
      $display("FAIL rand_count: %0d results, expected %0d", got, n);
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Start   = 1'b0;
    A       = '0;
    B       = '0;
    test_power_on();
    test_basic_signs();
    test_reset();
    test_extremes();
    test_start_while_busy();
    test_operand_stability();
    test_random_back_to_back(1000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
